// File: rtl/reg_cmd_seq.sv
// reg_cmd_seq: turns handshaked register commands into single-cycle strobes for the shift/count register.
// Define REG_CMD_SEQ_ROR_EN to make op 111 rotate right; otherwise op 111 acts as NOP.
module reg_cmd_seq #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [CNT_W-1:0]  cmd_cnt,
    input  logic [DATA_W-1:0] reg_out,
    output logic              cl,
    output logic              ld,
    output logic              inc,
    output logic              dec,
    output logic              sr,
    output logic              ir,
    output logic              sl,
    output logic              il,
    output logic [DATA_W-1:0] in,
    output logic              busy,
    output logic              done
);
    localparam int IW = $clog2(DATA_W);
    localparam logic [2:0] OP_NOP = 3'd0, OP_CLR = 3'd1, OP_LOAD = 3'd2, OP_INC = 3'd3;
    localparam logic [2:0] OP_DEC = 3'd4, OP_SHR = 3'd5, OP_SHL = 3'd6, OP_ROR = 3'd7;
`ifdef REG_CMD_SEQ_ROR_EN
    localparam bit ROR_EN = 1'b1;
`else
    localparam bit ROR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t            r_state, w_state_nx;
    logic [2:0]        r_op, w_op_nx, w_src_op;
    logic [DATA_W-1:0] r_data, w_data_nx, w_src_data, w_in_nx;
    logic [CNT_W-1:0]  r_n, w_n_nx, r_i, w_i_nx, w_i_inc, w_beats;
    logic [IW-1:0]     w_idx;
    logic              w_go, w_done_nx, w_lsb, w_unused;
    logic              w_cl_nx, w_ld_nx, w_inc_nx, w_dec_nx, w_sr_nx, w_ir_nx, w_sl_nx, w_il_nx;

    assign w_unused = ^reg_out;
    assign w_i_inc  = r_i + CNT_W'(1);
    assign w_beats  = (cmd_op == OP_CLR || cmd_op == OP_LOAD) ? CNT_W'(1) :
                      (cmd_op == OP_NOP || (cmd_op == OP_ROR && !ROR_EN)) ? '0 : cmd_cnt;

    // Next beat is decoded from the live command at accept and from the latched one afterwards.
    // Later ROR beats are decoded while the previous shift is still pending, so reg_out[1] is the next LSB.
    always_comb begin
        w_state_nx = r_state;
        w_op_nx    = r_op;
        w_data_nx  = r_data;
        w_n_nx     = r_n;
        w_i_nx     = r_i;
        w_go       = 1'b0;
        w_done_nx  = 1'b0;
        w_src_op   = r_op;
        w_src_data = r_data;
        w_idx      = IW'(w_i_inc);
        w_lsb      = reg_out[1];
        case (r_state)
            S_IDLE: if (cmd_valid) begin
                w_op_nx    = cmd_op;
                w_data_nx  = cmd_data;
                w_n_nx     = w_beats;
                w_i_nx     = '0;
                w_src_op   = cmd_op;
                w_src_data = cmd_data;
                w_idx      = '0;
                w_lsb      = reg_out[0];
                w_go       = w_beats != '0;
                w_done_nx  = !w_go;
                w_state_nx = w_go ? S_EXEC : S_DONE;
            end
            S_EXEC: begin
                w_go       = w_i_inc != r_n;
                w_done_nx  = !w_go;
                w_i_nx     = w_i_inc;
                w_state_nx = w_go ? S_EXEC : S_DONE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign w_cl_nx  = w_go && w_src_op == OP_CLR;
    assign w_ld_nx  = w_go && w_src_op == OP_LOAD;
    assign w_inc_nx = w_go && w_src_op == OP_INC;
    assign w_dec_nx = w_go && w_src_op == OP_DEC;
    assign w_sr_nx  = w_go && (w_src_op == OP_SHR || (ROR_EN && w_src_op == OP_ROR));
    assign w_sl_nx  = w_go && w_src_op == OP_SHL;
    assign w_ir_nx  = w_go && ((w_src_op == OP_SHR && w_src_data[w_idx]) ||
                               (ROR_EN && w_src_op == OP_ROR && w_lsb));
    assign w_il_nx  = w_sl_nx && w_src_data[~w_idx];
    assign w_in_nx  = w_ld_nx ? w_src_data : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_op      <= OP_NOP;
            r_data    <= '0;
            r_n       <= '0;
            r_i       <= '0;
            cmd_ready <= 1'b1;
            {cl, ld, inc, dec, sr, ir, sl, il} <= '0;
            in        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_op      <= w_op_nx;
            r_data    <= w_data_nx;
            r_n       <= w_n_nx;
            r_i       <= w_i_nx;
            cmd_ready <= w_state_nx == S_IDLE;
            {cl, ld, inc, dec, sr, ir, sl, il} <=
                {w_cl_nx, w_ld_nx, w_inc_nx, w_dec_nx, w_sr_nx, w_ir_nx, w_sl_nx, w_il_nx};
            in        <= w_in_nx;
            busy      <= w_state_nx != S_IDLE;
            done      <= w_done_nx;
        end
    end
endmodule
